// File: rtl/data_memory_responder_pkg.sv
// dmem_types: MMIO offsets, STATUS bit indices and address-region enum for data_memory_responder
package dmem_types;
  localparam logic [5:0] CONSOLE_TX_OFF = 6'h00;
  localparam logic [5:0] STATUS_OFF = 6'h04;
  localparam logic [5:0] CYCLE_LO_OFF = 6'h08;
  localparam logic [5:0] CYCLE_HI_OFF = 6'h0C;
  localparam logic [5:0] HALT_OFF = 6'h10;
  localparam logic [5:0] ERROR_ADDR_OFF = 6'h14;
  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB = 8;
  typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_NONE} dmem_region_t;
endpackage

// File: rtl/data_memory_responder_byte_fifo.sv
// byte_fifo: synchronous FIFO with push/pop, full/empty and occupancy count; head reads 0 when empty
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: CPU data bus responder with word RAM and MMIO console/cycle/halt registers; DMEM_BOUNDS_CHECK_EN adds write bounds checking
module data_memory_responder
  import dmem_types::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write,
  input  logic        memory_we,
  output logic [31:0] memory_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        access_error
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [RAM_WORDS];
  logic [63:0] cycle;
  logic [CW-1:0] tx_count;
  logic tx_full, tx_empty, tx_pop, tx_push, overflow, mmio_we;
  logic [5:0] off;
  logic [31:0] status, error_addr;
  dmem_region_t region;
  assign off = memory_address[5:0];
  assign region = memory_address[31:AW+2] == '0 ? REGION_RAM :
                  memory_address[31:6] == MMIO_BASE[31:6] ? REGION_MMIO : REGION_NONE;
  assign mmio_we = memory_we && region == REGION_MMIO;
  assign tx_push = mmio_we && off == CONSOLE_TX_OFF;
  assign tx_valid = !tx_empty;
  assign tx_pop = tx_valid && tx_ready;
  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (memory_write[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );
  // word RAM write; address[1:0] is ignored so misaligned writes hit the aligned word
  always_ff @(posedge clk)
    if (memory_we && region == REGION_RAM) ram[memory_address[AW+1:2]] <= memory_write;
  // cycle counter (clear on CYCLE_LO write, frozen by halt), first-wins halt, sticky overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cycle <= '0;
      halt <= 1'b0;
      halt_code <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= (mmio_we && off == CYCLE_LO_OFF) ? '0 : halt ? cycle : cycle + 64'd1;
      if (mmio_we && off == HALT_OFF && !halt) begin
        halt <= 1'b1;
        halt_code <= memory_write;
      end
      if (tx_push && tx_full && !tx_pop) overflow <= 1'b1;
    end
`ifdef DMEM_BOUNDS_CHECK_EN
  logic bad_we;
  assign bad_we = memory_we && (memory_address[1:0] != 2'b00 || region == REGION_NONE ||
                  (region == REGION_MMIO && !(off inside {CONSOLE_TX_OFF, STATUS_OFF, CYCLE_LO_OFF,
                                                          CYCLE_HI_OFF, HALT_OFF, ERROR_ADDR_OFF})));
  // sticky error flag; address of the first offending write only
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      access_error <= 1'b0;
      error_addr <= '0;
    end else if (bad_we && !access_error) begin
      access_error <= 1'b1;
      error_addr <= memory_address;
    end
`else
  assign access_error = 1'b0;
  assign error_addr = '0;
`endif
  // STATUS register image
  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT] = tx_full;
    status[STATUS_EMPTY_BIT] = tx_empty;
    status[STATUS_OVERFLOW_BIT] = overflow;
    status[STATUS_COUNT_LSB +: 8] = 8'(tx_count);
  end
  // combinational read mux; unmapped addresses read 0
  always_comb begin
    memory_out = '0;
    if (region == REGION_RAM) memory_out = ram[memory_address[AW+1:2]];
    else if (region == REGION_MMIO)
      case (off)
        STATUS_OFF:     memory_out = status;
        CYCLE_LO_OFF:   memory_out = cycle[31:0];
        CYCLE_HI_OFF:   memory_out = cycle[63:32];
        ERROR_ADDR_OFF: memory_out = error_addr;
        default:        memory_out = '0;
      endcase
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed self-checking bench with a console byte scoreboard
module tb_data_memory_responder;
  import dmem_types::*;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  logic clk = 1'b0, rst = 1'b1, memory_we = 1'b0, tx_ready = 1'b0;
  logic [31:0] memory_address = '0, memory_write = '0;
  logic [31:0] memory_out, halt_code;
  logic [7:0] tx_data;
  logic tx_valid, halt, access_error;
  int tests = 0, fails = 0;
  logic [7:0] q [$];
  logic [31:0] r, c1;

  data_memory_responder dut (
    .clk(clk), .rst(rst), .memory_address(memory_address), .memory_write(memory_write),
    .memory_we(memory_we), .memory_out(memory_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .halt(halt), .halt_code(halt_code), .access_error(access_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memory_address = a;
    memory_write = d;
    memory_we = 1'b1;
    @(negedge clk);
    memory_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memory_address = a;
    #1;
    d = memory_out;
    @(negedge clk);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while (q.size() > 0 && n < 50) begin
      if (tx_valid) check("tx_data", tx_data, q.pop_front());
      @(negedge clk);
      n++;
    end
    check("drain_left", q.size(), 0);
    tx_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_halt", halt, 0);
    check("rst_halt_code", halt_code, 0);
    check("rst_access_error", access_error, 0);
    rd_check("rst_status", MB + STATUS_OFF, 32'h2);
    rd_check("rst_cycle_lo", MB + CYCLE_LO_OFF, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rd_check("cycle_100", MB + CYCLE_LO_OFF, 100);
    wr(MB + CYCLE_LO_OFF, 32'h1234);
    rd_check("cycle_clr0", MB + CYCLE_LO_OFF, 0);
    rd_check("cycle_clr1", MB + CYCLE_LO_OFF, 1);
    wr(32'h10, 32'hDEAD_BEEF);
    rd_check("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd_check("ram_13", 32'h13, 32'hDEAD_BEEF);
    memory_address = 32'h10;
    memory_write = 32'h1234_5678;
    memory_we = 1'b1;
    #1;
    check("ram_same_cycle_old", memory_out, 32'hDEAD_BEEF);
    @(negedge clk);
    memory_we = 1'b0;
    rd_check("ram_new", 32'h10, 32'h1234_5678);
    wr(32'hFFC, 32'hCAFE_0001);
    rd_check("ram_top", 32'hFFC, 32'hCAFE_0001);
    rd_check("ram_past_end", 32'h1000, 0);
    rd_check("mmio_unmapped", MB + 32'h18, 0);
    wr(MB + CONSOLE_TX_OFF, 32'h48);
    q.push_back(8'h48);
    wr(MB + CONSOLE_TX_OFF, 32'hFFFF_FF69);
    q.push_back(8'h69);
    rd_check("status_hi", MB + STATUS_OFF, 32'h0000_0200);
    rd_check("console_rd0", MB + CONSOLE_TX_OFF, 0);
    check("hi_tx_valid", tx_valid, 1);
    check("hi_head", tx_data, 8'h48);
    drain();
    check("hi_drained_valid", tx_valid, 0);
    rd_check("status_empty", MB + STATUS_OFF, 32'h2);
    for (int i = 0; i < 9; i++) begin
      wr(MB + CONSOLE_TX_OFF, 32'h10 + i);
      if (i < 8) q.push_back(8'(8'h10 + i));
    end
    rd_check("status_ovf", MB + STATUS_OFF, 32'h0000_0805);
    tx_ready = 1'b1;
    check("full_head", tx_data, q.pop_front());
    wr(MB + CONSOLE_TX_OFF, 32'hA5);
    tx_ready = 1'b0;
    q.push_back(8'hA5);
    rd_check("status_full_pushpop", MB + STATUS_OFF, 32'h0000_0805);
    drain();
    rd_check("status_after_ovf", MB + STATUS_OFF, 32'h6);
    rd(MB + CYCLE_LO_OFF, r);
    check("halt_pre", halt, 0);
    wr(MB + HALT_OFF, 32'h2A);
    rd(MB + CYCLE_LO_OFF, c1);
    check("cycle_at_halt", c1, r + 2);
    wr(MB + HALT_OFF, 32'h55);
    repeat (10) @(negedge clk);
    check("halt", halt, 1);
    check("halt_code", halt_code, 32'h2A);
    rd_check("cycle_frozen", MB + CYCLE_LO_OFF, c1);
    rd_check("cycle_hi", MB + CYCLE_HI_OFF, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    wr(32'h1002, 32'h1);
    check("err_set", access_error, 1);
    rd_check("err_addr", MB + ERROR_ADDR_OFF, 32'h1002);
    wr(32'h8000_0000, 32'h2);
    rd_check("err_addr_first", MB + ERROR_ADDR_OFF, 32'h1002);
    check("err_sticky", access_error, 1);
`else
    wr(32'h1002, 32'h1);
    check("err_tied", access_error, 0);
    rd_check("err_addr_zero", MB + ERROR_ADDR_OFF, 0);
`endif
    wr(32'h22, 32'h0000_ABCD);
    rd_check("ram_misaligned", 32'h20, 32'h0000_ABCD);
    wr(MB + CONSOLE_TX_OFF, 32'h77);
    check("pre_rst_valid", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_halt", halt, 0);
    check("mid_rst_halt_code", halt_code, 0);
    check("mid_rst_err", access_error, 0);
    @(negedge clk);
    rd_check("mid_rst_status", MB + STATUS_OFF, 32'h2);
    rd_check("mid_rst_cycle", MB + CYCLE_LO_OFF, 0);
    rst = 1'b0;
    q.delete();
    rd_check("ram_kept", 32'h10, 32'h1234_5678);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
